seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Inverse of the binary-to-seven-segment encoder. Samples a multiplexed, active-low
//  seven-segment bus (digit enables AN + segments SEV[0:6]=a..g) as it is scanned, and
//  recovers the 4-bit hex value of each digit. Delivers one multi-digit frame per full
//  scan over a valid/ready handshake. Used as a display monitor and self-check on the
//  digital-clock datapath.
// PARAMETERS
//  NUM_DIGITS     4   digits per frame; AN width; VALUE = 4*NUM_DIGITS bits
//  STABLE_CYCLES  4   consecutive identical samples required to capture a digit (>=2)
// PORTS
//  CLK          in   1             system clock, all logic on rising edge
//  RST_N        in   1             synchronous reset, active-low
//  AN           in   NUM_DIGITS    digit enables, active-low; bit i low = digit i driven
//  SEV          in   [0:6]         segments a..g, active-low (0 = lit)
//  FRAME_READY  in   1             consumer accepts frame when high with FRAME_VALID
//  FRAME_VALID  out  1             VALUE/DIGIT_ERR hold a complete unconsumed frame
//  VALUE        out  4*NUM_DIGITS  nibble i = decoded digit i (digit 0 = bits 3:0)
//  DIGIT_ERR    out  NUM_DIGITS    bit i set: digit i pattern not in table
//  OVERRUN      out  1             sticky: frame completed while previous one unconsumed
// BEHAVIOUR
//  - Decode table, SEV[0:6] -> nibble: 0000001=0 1001111=1 0010010=2 0000110=3
//    1001100=4 0100100=5 0100000=6 0001111=7 0000000=8 0001100=9 0001000=A
//    1100000=b 0110001=C 1000010=d 0110000=E 0111000=F. Any other: nibble 0, error bit 1.
//  - Sample reg S1 <= {AN,SEV} every edge. cnt: if {AN,SEV}==S1 then cnt<=min(cnt+1,
//    STABLE_CYCLES) else cnt<=0. cap = (cnt==STABLE_CYCLES-1) && S1.AN has exactly one 0.
//  - Input held for STABLE_CYCLES sampled edges -> cap high for exactly one cycle; digit
//    slot i (the low AN bit) written at next edge: shadow nibble, shadow err, mask[i]<=1.
//    cnt saturation guarantees one capture per stable window however long it is held.
//  - AN all ones (blanking) or >1 low bit: never captures; cnt still tracks stability.
//  - Same digit captured again before frame completes: overwrite nibble and err bit.
//  - Frame complete: at the edge where the capture makes mask all ones (new digit
//    included): if FRAME_VALID==0 or FRAME_READY==1 -> VALUE/DIGIT_ERR load shadow,
//    FRAME_VALID<=1; else OVERRUN<=1, frame dropped, outputs untouched. Mask cleared
//    either way.
//  - Handshake: FRAME_VALID&&FRAME_READY at an edge consumes frame; FRAME_VALID<=0 unless
//    a new frame loads at that same edge (then stays 1 with new data). VALUE/DIGIT_ERR
//    stable while FRAME_VALID=1 and not consumed. FRAME_READY ignored when FRAME_VALID=0.
//  - OVERRUN cleared only by reset.
//  - Reset (any time, incl. mid-scan): S1<={all ones}, cnt<=0, mask<=0, shadow<=0,
//    VALUE=0, DIGIT_ERR=0, FRAME_VALID=0, OVERRUN=0. Partial scan discarded.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  1 RST_N=0 for 2 edges with random AN/SEV -> all outputs 0, no FRAME_VALID afterwards
//    until 4 digits captured.
//  2 AN=1110/SEV=1001111, 1101/0010010, 1011/0000110, 0111/1001100, each held 6 cycles,
//    READY=0 -> FRAME_VALID=1 at edge of 4th capture, VALUE=16'h4321, DIGIT_ERR=0000.
//  3 Scan E,d,C,b (0110000,1000010,0110001,1100000) on digits 3..0 -> VALUE=16'hEDCB;
//    a digit held only 3 samples between them -> not captured, no frame until re-held 4.
//  4 Digit 2 driven SEV=1111111, others valid -> VALUE[11:8]=0, DIGIT_ERR=0100.
//  5 FRAME_VALID=1, READY=0, second full scan -> OVERRUN=1, VALUE unchanged; then READY=1
//    one cycle -> FRAME_VALID=0 next edge; READY=1 on completing edge -> new frame, VALID 1.
//  6 RST_N pulsed low after 2 digits captured, then scan digits 2,3 only -> no frame;
//    scanning digits 0,1 afterwards completes frame.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the seven-segment monitor bus and the frame valid/ready output
// channel. The slave side is the decoder; the master side drives the display bus.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   AN;
    logic [0:6]              SEV;
    logic                    FRAME_READY;
    logic                    FRAME_VALID;
    logic [4*NUM_DIGITS-1:0] VALUE;
    logic [NUM_DIGITS-1:0]   DIGIT_ERR;
    logic                    OVERRUN;

    modport master (
        output AN, SEV, FRAME_READY,
        input  FRAME_VALID, VALUE, DIGIT_ERR, OVERRUN
    );

    modport slave (
        input  AN, SEV, FRAME_READY,
        output FRAME_VALID, VALUE, DIGIT_ERR, OVERRUN
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a scanned active-low seven-segment bus, recovers each digit's hex value
// once its pattern has been stable long enough, and hands out one frame per full scan.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    seg7_scan_decoder_if.slave  bus
);
    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CAP_AT  = CNT_W'(STABLE_CYCLES - 1);

    // Returns {error, nibble}; unknown patterns decode to 0 with the error bit set.
    function automatic logic [4:0] decode_seg(input logic [0:6] seg);
        case (seg)
            7'b0000001: return 5'h00;
            7'b1001111: return 5'h01;
            7'b0010010: return 5'h02;
            7'b0000110: return 5'h03;
            7'b1001100: return 5'h04;
            7'b0100100: return 5'h05;
            7'b0100000: return 5'h06;
            7'b0001111: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0001100: return 5'h09;
            7'b0001000: return 5'h0A;
            7'b1100000: return 5'h0B;
            7'b0110001: return 5'h0C;
            7'b1000010: return 5'h0D;
            7'b0110000: return 5'h0E;
            7'b0111000: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0]   s1_an_q, s1_an_d;
    logic [0:6]              s1_sev_q, s1_sev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_DIGITS-1:0]   slot_oh;
    logic [4:0]              dec;
    logic                    cap;
    logic                    load;

    always_comb begin
        s1_an_d       = bus.AN;
        s1_sev_d      = bus.SEV;
        cnt_d         = '0;
        mask_d        = mask_q;
        shadow_val_d  = shadow_val_q;
        shadow_err_d  = shadow_err_q;
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        load          = 1'b0;

        // Saturating at STABLE_CYCLES makes cap fire once per stable window.
        if (bus.AN == s1_an_q && bus.SEV == s1_sev_q)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        slot_oh = ~s1_an_q;
        dec     = decode_seg(s1_sev_q);
        cap     = (cnt_q == CAP_AT) && ($countones(slot_oh) == 1);

        if (cap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot_oh[i]) begin
                    shadow_val_d[4*i +: 4] = dec[3:0];
                    shadow_err_d[i]        = dec[4];
                end
            end
            mask_d = mask_q | slot_oh;
            if (&mask_d) begin
                mask_d = '0;
                if (!frame_valid_q || bus.FRAME_READY) begin
                    value_d     = shadow_val_d;
                    digit_err_d = shadow_err_d;
                    load        = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end

        if (load)
            frame_valid_d = 1'b1;
        else if (frame_valid_q && bus.FRAME_READY)
            frame_valid_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_an_q       <= '1;
            s1_sev_q      <= '1;
            cnt_q         <= '0;
            mask_q        <= '0;
            shadow_val_q  <= '0;
            shadow_err_q  <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            s1_an_q       <= s1_an_d;
            s1_sev_q      <= s1_sev_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            shadow_val_q  <= shadow_val_d;
            shadow_err_q  <= shadow_err_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.FRAME_VALID = frame_valid_q;
    assign bus.VALUE       = value_q;
    assign bus.DIGIT_ERR   = digit_err_q;
    assign bus.OVERRUN     = overrun_q;
endmodule
